// File: rtl/ispm_arb_if.sv
// Bus-side request/response bundle for the scratchpad's shared port B.
// The master drives requests and the arbiter (slave) returns ready, completion and read data.
interface ispm_arb_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    write;
    logic [DATA_WIDTH/8-1:0] mask;
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    resp_valid;
    logic [DATA_WIDTH-1:0]   data_out;

    modport master (
        output valid, addr, write, mask, data_in,
        input  ready, resp_valid, data_out
    );

    modport slave (
        input  valid, addr, write, mask, data_in,
        output ready, resp_valid, data_out
    );
endinterface

// File: rtl/ispm_arb.sv
// Instruction scratchpad: port A serves core fetch, port B is shared between core load/store
// and a one-entry buffered bus request that may yield to the core at most MAX_WAIT cycles.
module ispm_arb #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   io_core_r_addr,
    input  logic                    io_core_r_enable,
    output logic [DATA_WIDTH-1:0]   io_core_r_data_out,
    input  logic [ADDR_WIDTH-1:0]   io_core_rw_addr,
    input  logic                    io_core_rw_enable,
    input  logic                    io_core_rw_write,
    input  logic [DATA_WIDTH/8-1:0] io_core_rw_mask,
    input  logic [DATA_WIDTH-1:0]   io_core_rw_data_in,
    output logic [DATA_WIDTH-1:0]   io_core_rw_data_out,
    output logic                    io_core_rw_stall,
    ispm_arb_if.slave               io_bus
);
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {StIdle, StPend, StResp} state_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic [WAIT_W-1:0]     w_wait_nxt;
    logic                  w_capture;
    logic                  w_bus_go;
    logic                  w_stall;
    logic                  w_core_go;

    logic [ADDR_WIDTH-1:0] r_buf_addr;
    logic                  r_buf_write;
    logic [NBYTES-1:0]     r_buf_mask;
    logic [DATA_WIDTH-1:0] r_buf_data;

    logic [ADDR_WIDTH-1:0] w_b_addr;
    logic                  w_b_we;
    logic [NBYTES-1:0]     w_b_mask;
    logic [DATA_WIDTH-1:0] w_b_wdata;

    logic [DATA_WIDTH-1:0] r_r_data;
    logic [DATA_WIDTH-1:0] r_rw_data;
    logic [DATA_WIDTH-1:0] r_bus_data;

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_capture   = 1'b0;
        w_bus_go    = 1'b0;
        w_stall     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (io_bus.valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = StPend;
                end
            end
            StPend: begin
                if (!io_core_rw_enable || r_wait_cnt == WAIT_MAX) begin
                    w_bus_go    = 1'b1;
                    w_stall     = io_core_rw_enable;
                    w_state_nxt = StResp;
                end else begin
                    // Only reached below WAIT_MAX, so the increment saturates by construction.
                    w_wait_nxt = r_wait_cnt + 1'b1;
                end
            end
            StResp: begin
                w_wait_nxt  = '0;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_core_go = io_core_rw_enable && !w_stall;
        w_b_addr  = w_bus_go ? r_buf_addr  : io_core_rw_addr;
        w_b_we    = w_bus_go ? r_buf_write : (w_core_go && io_core_rw_write);
        w_b_mask  = w_bus_go ? r_buf_mask  : io_core_rw_mask;
        w_b_wdata = w_bus_go ? r_buf_data  : io_core_rw_data_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_wait_cnt  <= '0;
            r_buf_addr  <= '0;
            r_buf_write <= 1'b0;
            r_buf_mask  <= '0;
            r_buf_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_capture) begin
                r_buf_addr  <= io_bus.addr;
                r_buf_write <= io_bus.write;
                r_buf_mask  <= io_bus.mask;
                r_buf_data  <= io_bus.data_in;
            end
        end
    end

    // Writes land at the edge, so same-cycle reads on either port see the old word.
    always_ff @(posedge clk) begin
        if (w_b_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (w_b_mask[b]) begin
                    r_mem[w_b_addr][8*b +: 8] <= w_b_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_r_data   <= '0;
            r_rw_data  <= '0;
            r_bus_data <= '0;
        end else begin
            if (io_core_r_enable) begin
                r_r_data <= r_mem[io_core_r_addr];
            end
            if (w_core_go) begin
                r_rw_data <= r_mem[w_b_addr];
            end
            if (w_bus_go && !r_buf_write) begin
                r_bus_data <= r_mem[w_b_addr];
            end
        end
    end

    assign io_core_r_data_out  = r_r_data;
    assign io_core_rw_data_out = r_rw_data;
    assign io_core_rw_stall    = w_stall;
    assign io_bus.ready        = (r_state == StIdle);
    assign io_bus.resp_valid   = (r_state == StResp);
    assign io_bus.data_out     = r_bus_data;
endmodule

// File: tb/tb_ispm_arb.sv
// Self-checking bench for ispm_arb: directed scenarios plus randomized bus/core traffic
// checked against a word-array memory model and a per-transaction arbitration prediction.
module tb_ispm_arb;
    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 32;
    localparam int unsigned MW    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] r_addr;
    logic          r_en;
    logic [DW-1:0] r_data, r_data0;
    logic [AW-1:0] rw_addr;
    logic          rw_en, rw_write;
    logic [3:0]    rw_mask;
    logic [DW-1:0] rw_din, rw_dout, rw_dout0;
    logic          stall, stall0;

    logic [DW-1:0] mem_m [DEPTH];
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    ispm_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    ispm_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();

    ispm_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset_n(reset_n),
        .io_core_r_addr(r_addr), .io_core_r_enable(r_en), .io_core_r_data_out(r_data),
        .io_core_rw_addr(rw_addr), .io_core_rw_enable(rw_en), .io_core_rw_write(rw_write),
        .io_core_rw_mask(rw_mask), .io_core_rw_data_in(rw_din),
        .io_core_rw_data_out(rw_dout), .io_core_rw_stall(stall), .io_bus(bus)
    );

    // Second instance exercises the MAX_WAIT=0 boundary; core inputs are shared.
    ispm_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .io_core_r_addr(r_addr), .io_core_r_enable(r_en), .io_core_r_data_out(r_data0),
        .io_core_rw_addr(rw_addr), .io_core_rw_enable(rw_en), .io_core_rw_write(rw_write),
        .io_core_rw_mask(rw_mask), .io_core_rw_data_in(rw_din),
        .io_core_rw_data_out(rw_dout0), .io_core_rw_stall(stall0), .io_bus(bus0)
    );

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [3:0] m);
        logic [DW-1:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_access(input logic [AW-1:0] a, input logic w, input logic [3:0] m,
                               input logic [DW-1:0] d, output logic [DW-1:0] rd);
        rw_en = 1'b1; rw_addr = a; rw_write = w; rw_mask = m; rw_din = d;
        tick();
        rw_en = 1'b0; rw_write = 1'b0;
        rd = rw_dout;
        if (w) mem_m[a] = merge(mem_m[a], d, m);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL reset_r_data got=%h exp=0", r_data); end
        checks++; if (rw_dout !== 32'h0) begin errors++; $display("FAIL reset_rw_data got=%h exp=0", rw_dout); end
        checks++; if (bus.data_out !== 32'h0) begin errors++; $display("FAIL reset_bus_data got=%h exp=0", bus.data_out); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
        reset_n = 1'b1;
        tick();
        tick();
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (r_data !== 32'h0 || rw_dout !== 32'h0) begin
            errors++; $display("FAIL idle_hold got=%h/%h exp=0/0", r_data, rw_dout);
        end
    endtask

    task automatic test_core_store();
        logic [DW-1:0] rd;
        core_access(12'h010, 1'b1, 4'hF, 32'h11223344, rd);
        core_access(12'h010, 1'b1, 4'b0011, 32'hDEADBEEF, rd);
        checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL store_read_first got=%h exp=11223344", rd); end
        core_access(12'h010, 1'b0, 4'h0, 32'h0, rd);
        checks++; if (rd !== 32'h1122BEEF) begin errors++; $display("FAIL store_masked got=%h exp=1122beef", rd); end
        tick();
        checks++; if (rw_dout !== 32'h1122BEEF) begin errors++; $display("FAIL rw_hold got=%h exp=1122beef", rw_dout); end
    endtask

    task automatic test_bus_write();
        bus.valid = 1'b1; bus.addr = 12'h020; bus.write = 1'b1; bus.mask = 4'hF;
        bus.data_in = 32'hCAFEF00D;
        #1;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL bw_ready_idle got=%b exp=1", bus.ready); end
        tick();
        bus.valid = 1'b0;
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL bw_ready_pend got=%b exp=0", bus.ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL bw_resp_early got=%b exp=0", bus.resp_valid); end
        tick();
        checks++; if (bus.resp_valid !== 1'b1 || bus.ready !== 1'b0) begin
            errors++; $display("FAIL bw_resp got=%b/%b exp=1/0", bus.resp_valid, bus.ready);
        end
        tick();
        checks++; if (bus.resp_valid !== 1'b0 || bus.ready !== 1'b1) begin
            errors++; $display("FAIL bw_done got=%b/%b exp=0/1", bus.resp_valid, bus.ready);
        end
        mem_m[12'h020] = 32'hCAFEF00D;
        r_en = 1'b1; r_addr = 12'h020;
        tick();
        r_en = 1'b0;
        checks++; if (r_data !== 32'hCAFEF00D) begin errors++; $display("FAIL bw_porta got=%h exp=cafef00d", r_data); end
    endtask

    task automatic test_forced();
        logic [DW-1:0] rd;
        int            stalls;
        core_access(12'h050, 1'b1, 4'hF, 32'h0, rd);
        stalls = 0;
        rw_en = 1'b1; rw_write = 1'b0; rw_addr = 12'h050;
        bus.valid = 1'b1; bus.addr = 12'h020; bus.write = 1'b0;
        #1;
        if (stall === 1'b1) stalls++;
        tick();
        bus.valid = 1'b0;
        for (int i = 0; i < MW; i++) begin
            #1;
            if (stall === 1'b1) stalls++;
            tick();
        end
        rw_write = 1'b1; rw_din = 32'hBAD0BAD0; rw_mask = 4'hF;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL forced_stall got=%b exp=1", stall); end
        tick();
        rw_write = 1'b0;
        #1;
        if (stall === 1'b1) stalls++;
        checks++; if (stalls != 0) begin errors++; $display("FAIL yield_stalls got=%0d exp=0", stalls); end
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL forced_resp got=%b exp=1", bus.resp_valid); end
        checks++; if (bus.data_out !== 32'hCAFEF00D) begin errors++; $display("FAIL forced_data got=%h exp=cafef00d", bus.data_out); end
        tick();
        rw_en = 1'b0;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL resp_pulse got=%b exp=0", bus.resp_valid); end
        checks++; if (rw_dout !== 32'h0) begin errors++; $display("FAIL stall_dropped got=%h exp=0", rw_dout); end
    endtask

    task automatic test_collision();
        logic [DW-1:0] rd;
        core_access(12'h030, 1'b1, 4'hF, 32'h0, rd);
        r_en = 1'b1; r_addr = 12'h030;
        core_access(12'h030, 1'b1, 4'hF, 32'h5, rd);
        checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL coll_old got=%h exp=0", r_data); end
        tick();
        r_en = 1'b0;
        checks++; if (r_data !== 32'h5) begin errors++; $display("FAIL coll_new got=%h exp=5", r_data); end
    endtask

    task automatic test_max_wait_zero();
        rw_en = 1'b1; rw_write = 1'b0; rw_addr = 12'h000;
        bus0.valid = 1'b1; bus0.addr = 12'h000; bus0.write = 1'b0;
        #1;
        checks++; if (stall0 !== 1'b0 || bus0.ready !== 1'b1) begin
            errors++; $display("FAIL mw0_idle got=%b/%b exp=0/1", stall0, bus0.ready);
        end
        tick();
        bus0.valid = 1'b0;
        checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL mw0_stall got=%b exp=1", stall0); end
        tick();
        checks++; if (stall0 !== 1'b0 || bus0.resp_valid !== 1'b1) begin
            errors++; $display("FAIL mw0_resp got=%b/%b exp=0/1", stall0, bus0.resp_valid);
        end
        rw_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] rd;
        core_access(12'h040, 1'b1, 4'hF, 32'h12345678, rd);
        rw_en = 1'b1; rw_write = 1'b0; rw_addr = 12'h060;
        bus.valid = 1'b1; bus.addr = 12'h040; bus.write = 1'b1; bus.mask = 4'hF;
        bus.data_in = 32'hFFFFFFFF;
        tick();
        bus.valid = 1'b0;
        tick();
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL rm_pend got=%b exp=0", bus.ready); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.ready !== 1'b1 || bus.resp_valid !== 1'b0 || rw_dout !== 32'h0) begin
            errors++; $display("FAIL rm_async got=%b/%b/%h exp=1/0/0", bus.ready, bus.resp_valid, rw_dout);
        end
        rw_en = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL rm_ready got=%b exp=1", bus.ready); end
        r_en = 1'b1; r_addr = 12'h040;
        tick();
        r_en = 1'b0;
        checks++; if (r_data !== 32'h12345678) begin errors++; $display("FAIL rm_unchanged got=%h exp=12345678", r_data); end
    endtask

    task automatic test_random();
        logic [DW-1:0] rd;
        logic [AW-1:0] base;
        base = 12'h100;
        for (int a = 0; a < 16; a++) core_access(base + AW'(a), 1'b1, 4'hF, $urandom, rd);
        for (int t = 0; t < 40; t++) begin
            logic [AW-1:0] b_addr;
            logic          b_wr;
            logic [3:0]    b_mask;
            logic [DW-1:0] b_data, exp_bus;
            logic          en_pat [MW+1];
            int            k;
            logic          found;
            b_addr = base + AW'($urandom_range(0, 15));
            b_wr = 1'($urandom); b_mask = 4'($urandom); b_data = $urandom;
            exp_bus = '0;
            for (int i = 0; i <= MW; i++) en_pat[i] = ($urandom_range(0, 3) != 0);
            // Bus executes on the first PEND cycle the core is idle, or after MW yields.
            k = MW; found = 1'b0;
            for (int i = 0; i <= MW; i++) if (!found && !en_pat[i]) begin k = i; found = 1'b1; end
            for (int c = 0; c <= k + 2; c++) begin
                logic          core_en, bus_exec, exp_stall, core_exec;
                logic [AW-1:0] ca;
                logic [DW-1:0] exp_a, exp_rw;
                core_en = (c >= 1 && c <= k + 1) ? en_pat[c-1] : ($urandom_range(0, 3) != 0);
                ca = base + AW'($urandom_range(0, 15));
                bus_exec  = (c == k + 1);
                exp_stall = bus_exec && core_en;
                core_exec = core_en && !exp_stall;
                rw_en = core_en; rw_addr = ca; rw_write = 1'($urandom);
                rw_mask = 4'($urandom); rw_din = $urandom;
                r_en = 1'($urandom); r_addr = base + AW'($urandom_range(0, 15));
                bus.valid = (c == 0); bus.addr = b_addr; bus.write = b_wr;
                bus.mask = b_mask; bus.data_in = b_data;
                #1;
                checks++; if (stall !== exp_stall) begin
                    errors++; $display("FAIL rnd_stall t=%0d c=%0d got=%b exp=%b", t, c, stall, exp_stall);
                end
                checks++; if (bus.ready !== (c == 0)) begin
                    errors++; $display("FAIL rnd_ready t=%0d c=%0d got=%b exp=%b", t, c, bus.ready, c == 0);
                end
                checks++; if (bus.resp_valid !== (c == k + 2)) begin
                    errors++; $display("FAIL rnd_resp t=%0d c=%0d got=%b exp=%b", t, c, bus.resp_valid, c == k + 2);
                end
                if (c == k + 2 && !b_wr) begin
                    checks++; if (bus.data_out !== exp_bus) begin
                        errors++; $display("FAIL rnd_bus_data t=%0d got=%h exp=%h", t, bus.data_out, exp_bus);
                    end
                end
                exp_a = mem_m[r_addr];
                exp_rw = mem_m[ca];
                if (core_exec && rw_write) mem_m[ca] = merge(mem_m[ca], rw_din, rw_mask);
                if (bus_exec) begin
                    if (b_wr) mem_m[b_addr] = merge(mem_m[b_addr], b_data, b_mask);
                    else      exp_bus = mem_m[b_addr];
                end
                tick();
                if (r_en) begin
                    checks++; if (r_data !== exp_a) begin
                        errors++; $display("FAIL rnd_porta t=%0d c=%0d got=%h exp=%h", t, c, r_data, exp_a);
                    end
                end
                if (core_exec) begin
                    checks++; if (rw_dout !== exp_rw) begin
                        errors++; $display("FAIL rnd_portb t=%0d c=%0d got=%h exp=%h", t, c, rw_dout, exp_rw);
                    end
                end
            end
            bus.valid = 1'b0; rw_en = 1'b0; r_en = 1'b0;
        end
    endtask

    initial begin
        r_en = 1'b0; r_addr = '0;
        rw_en = 1'b0; rw_write = 1'b0; rw_addr = '0; rw_mask = '0; rw_din = '0;
        bus.valid = 1'b0; bus.addr = '0; bus.write = 1'b0; bus.mask = '0; bus.data_in = '0;
        bus0.valid = 1'b0; bus0.addr = '0; bus0.write = 1'b0; bus0.mask = '0; bus0.data_in = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_core_store();
        test_bus_write();
        test_forced();
        test_collision();
        test_max_wait_zero();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
